// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bundle: redirect/stall controls, instruction-memory handshake and IF/ID-facing outputs.
// Single-outstanding request/response; the downstream stage stalls the fetch unit through ID_redo.
interface if_fetch_unit_if;
  logic        branch_flush;
  logic [31:0] redirect_pc_i;
  logic        ID_redo;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_valid_i;
  logic [31:0] imem_rdata_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic [31:0] pc_add4_o;

  modport master (
    input  branch_flush, redirect_pc_i, ID_redo, imem_valid_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, valid_o, pc_o, instr_o, pc_add4_o
  );

  modport slave (
    output branch_flush, redirect_pc_i, ID_redo, imem_valid_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, valid_o, pc_o, instr_o, pc_add4_o
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: one outstanding imem request, one-entry output buffer; L-cycle memory gives one instruction per L+1 cycles.
// ID_redo holds the buffer and blocks new requests; branch_flush clears the buffer and redirects the PC.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk_i,
  input logic          rst_i,
  if_fetch_unit_if.master bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic        kill;

  logic        buf_valid;
  logic [31:0] buf_pc;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc_add4;

  logic        consume;
  logic        free;
  logic        req;
  logic        resp;
  logic        load;

  assign consume = buf_valid & ~bus.ID_redo & ~bus.branch_flush;
  assign free    = ~buf_valid | consume;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = WAIT;
      WAIT: if (bus.imem_valid_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A response seen in IDLE is a leftover from before a reset and is never used.
  always_comb begin
    req  = 1'b0;
    resp = 1'b0;
    case (state)
      IDLE: req  = free & ~bus.branch_flush & ~rst_i;
      WAIT: resp = bus.imem_valid_i;
      default: begin
        req  = 1'b0;
        resp = 1'b0;
      end
    endcase
  end

  assign load = resp & ~kill & ~bus.branch_flush;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc <= RESET_PC;
    end else if (bus.branch_flush) begin
      pc <= bus.redirect_pc_i & 32'hFFFF_FFFC;
    end else if (load) begin
      pc <= pc + 32'd4;
    end
  end

  // kill marks the outstanding response as stale; it is retired by that response alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kill <= 1'b0;
    end else if (resp) begin
      kill <= 1'b0;
    end else if (bus.branch_flush && state == WAIT) begin
      kill <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.branch_flush) begin
      buf_valid   <= 1'b0;
      buf_pc      <= 32'd0;
      buf_instr   <= 32'd0;
      buf_pc_add4 <= 32'd0;
    end else if (load) begin
      buf_valid   <= 1'b1;
      buf_pc      <= pc;
      buf_instr   <= bus.imem_rdata_i;
      buf_pc_add4 <= pc + 32'd4;
    end else if (consume) begin
      buf_valid   <= 1'b0;
      buf_pc      <= 32'd0;
      buf_instr   <= 32'd0;
      buf_pc_add4 <= 32'd0;
    end
  end

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = pc;
  assign bus.valid_o     = buf_valid;
  assign bus.pc_o        = buf_pc;
  assign bus.instr_o     = buf_instr;
  assign bus.pc_add4_o   = buf_pc_add4;

endmodule
